// File: rtl/fetch_queue_pkg.sv
// Pipeline-wide constants and the queue entry layout shared by fetch, queue and decode.
package fetch_queue_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] ARM_NOP = 32'hE1A00000; // MOV R0,R0

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc_plus_4;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle; master is the pipeline side, slave is the queue.
interface fetch_queue_if #(parameter int AW = 2);
  logic                                fetch_valid;
  logic [fetch_queue_pkg::INSTR_W-1:0] if_instruction;
  logic [fetch_queue_pkg::INSTR_W-1:0] if_pc_plus_4;
  logic                                flush;
  logic                                if_stall;
  logic                                id_valid;
  logic                                id_ready;
  logic [fetch_queue_pkg::INSTR_W-1:0] id_instruction;
  logic [fetch_queue_pkg::INSTR_W-1:0] id_pc_plus_4;
  logic [AW:0]                         occupancy;

  modport master (
    output fetch_valid, if_instruction, if_pc_plus_4, flush, id_ready,
    input  if_stall, id_valid, id_instruction, id_pc_plus_4, occupancy
  );
  modport slave (
    input  fetch_valid, if_instruction, if_pc_plus_4, flush, id_ready,
    output if_stall, id_valid, id_instruction, id_pc_plus_4, occupancy
  );
endinterface

// File: rtl/fetch_queue_mem.sv
// DEPTH x 64-bit entry store: one synchronous write port, one combinational read port.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fq_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output fq_entry_t     rdata
);
  // Contents are never reset; the head is masked by id_valid upstream.
  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling queue: first-word fall-through, registered stall, flush wipe.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  bus
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, empty, enq, deq;
  fq_entry_t     head, wdata;

  // Stall is a pure function of count so fetch never sees a same-cycle loop.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign enq   = bus.fetch_valid & ~full & ~bus.flush;
  assign deq   = ~empty & bus.id_ready & ~bus.flush;
  assign wdata = '{instr: bus.if_instruction, pc_plus_4: bus.if_pc_plus_4};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (bus.flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      if (enq && !deq)      count <= count + 1'b1;
      else if (deq && !enq) count <= count - 1'b1;
    end
  end

  fetch_queue_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (enq),
    .waddr (wptr),
    .wdata (wdata),
    .raddr (rptr),
    .rdata (head)
  );

  assign bus.if_stall       = full;
  assign bus.id_valid       = ~empty;
  assign bus.id_instruction = empty ? ARM_NOP : head.instr;
  assign bus.id_pc_plus_4   = empty ? '0 : head.pc_plus_4;
  assign bus.occupancy      = count;
endmodule
